// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: diff = a - b - bin, LSB first, one full-subtractor
// step per clock, with valid/ready handshakes on both the operand and result sides.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             bin_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] diff_o,
    output logic             bout_o,
    output logic             busy_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             borrow_q, borrow_d;
    logic             bout_q, bout_d;

    logic             d_bit;
    logic             borrow_next;

    // Single full-subtractor cell acting on the current LSBs.
    assign d_bit       = sa_q[0] ^ sb_q[0] ^ borrow_q;
    assign borrow_next = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & borrow_q);

    always_comb begin
        state_d  = state_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        diff_d   = diff_q;
        cnt_d    = cnt_q;
        borrow_d = borrow_q;
        bout_d   = bout_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    sa_d     = a_i;
                    sb_d     = b_i;
                    borrow_d = bin_i;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                sa_d            = sa_q >> 1;
                sb_d            = sb_q >> 1;
                diff_d          = diff_q >> 1;
                diff_d[WIDTH-1] = d_bit;
                borrow_d        = borrow_next;
                cnt_d           = cnt_q + CW'(1);
                if (cnt_q == LAST_CNT) begin
                    bout_d  = borrow_next;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            diff_q   <= diff_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
            bout_q   <= bout_d;
        end
    end

    assign in_ready_o  = (state_q == IDLE);
    assign out_valid_o = (state_q == DONE);
    assign busy_o      = (state_q == RUN) || (state_q == DONE);
    assign diff_o      = diff_q;
    assign bout_o      = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=4) against an arithmetic reference.
module tb_serial_subtractor;

    localparam int W = 4;

    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b0;
    logic         in_valid_i = 1'b0;
    logic         in_ready_o;
    logic [W-1:0] a_i = '0;
    logic [W-1:0] b_i = '0;
    logic         bin_i = 1'b0;
    logic         out_valid_o;
    logic         out_ready_i = 1'b0;
    logic [W-1:0] diff_o;
    logic         bout_o;
    logic         busy_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .a_i        (a_i),
        .b_i        (b_i),
        .bin_i      (bin_i),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .diff_o     (diff_o),
        .bout_o     (bout_o),
        .busy_o     (busy_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Reference: {bout, diff} is the (W+1)-bit wrap of a - b - bin.
    function automatic logic [W:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic bin);
        ref_sub = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Presents operands, waits for acceptance, then waits for out_valid (left in DONE).
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                          output int lat);
        int guard;
        guard = 0;
        while (!in_ready_o && guard < 40) begin
            tick();
            guard++;
        end
        a_i = a;
        b_i = b;
        bin_i = bin;
        in_valid_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        lat = 1;
        while (!out_valid_o && lat < 40) begin
            tick();
            lat++;
        end
        if (!out_valid_o) begin
            checks++;
            errors++;
            $display("FAIL run_op_timeout: out_valid=%0b required 1 within 40 cycles", out_valid_o);
        end
        lat = lat - 1;
    endtask

    task automatic handshake();
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        int lat;
        rst_ni = 1'b0;
        #12;
        checks++;
        if ({in_ready_o, out_valid_o, busy_o, bout_o, diff_o} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'h0}) begin
            errors++;
            $display("FAIL reset_state: rdy/vld/busy/bout/diff=%b required 10000000",
                     {in_ready_o, out_valid_o, busy_o, bout_o, diff_o});
        end
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        // Start an op and kill it mid-RUN with an asynchronous reset.
        a_i = 4'd9; b_i = 4'd3; bin_i = 1'b0; in_valid_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        tick();
        tick();
        #2 rst_ni = 1'b0;
        #1;
        checks++;
        if ({in_ready_o, out_valid_o, busy_o, bout_o, diff_o} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'h0}) begin
            errors++;
            $display("FAIL reset_midrun: rdy/vld/busy/bout/diff=%b required 10000000",
                     {in_ready_o, out_valid_o, busy_o, bout_o, diff_o});
        end
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        run_op(4'd5, 4'd2, 1'b0, lat);
        checks++;
        if ({bout_o, diff_o} !== 5'd3) begin
            errors++;
            $display("FAIL reset_after_op: {bout,diff}=%h required 03", {bout_o, diff_o});
        end
        handshake();
    endtask

    task automatic test_basic();
        int lat;
        run_op(4'd9, 4'd3, 1'b0, lat);
        checks++;
        if (lat !== W) begin
            errors++;
            $display("FAIL basic_latency: latency=%0d required %0d", lat, W);
        end
        checks++;
        if ({bout_o, diff_o} !== 5'd6) begin
            errors++;
            $display("FAIL basic_result: {bout,diff}=%h required 06", {bout_o, diff_o});
        end
        checks++;
        if ({in_ready_o, busy_o} !== 2'b01) begin
            errors++;
            $display("FAIL basic_flags_done: in_ready/busy=%b required 01", {in_ready_o, busy_o});
        end
        handshake();
    endtask

    task automatic test_borrow_wrap();
        logic [W-1:0] ta [3] = '{4'd3, 4'd0, 4'd15};
        logic [W-1:0] tb [3] = '{4'd9, 4'd0, 4'd15};
        logic         tc [3] = '{1'b0, 1'b1, 1'b0};
        logic [W:0]   exp;
        int lat;
        for (int i = 0; i < 3; i++) begin
            exp = ref_sub(ta[i], tb[i], tc[i]);
            run_op(ta[i], tb[i], tc[i], lat);
            checks++;
            if ({bout_o, diff_o} !== exp) begin
                errors++;
                $display("FAIL borrow_wrap_%0d: a=%0d b=%0d bin=%0b {bout,diff}=%h required %h",
                         i, ta[i], tb[i], tc[i], {bout_o, diff_o}, exp);
            end
            handshake();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        run_op(4'd12, 4'd5, 1'b0, lat);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if ({out_valid_o, in_ready_o, bout_o, diff_o} !== {1'b1, 1'b0, 5'd7}) begin
                errors++;
                $display("FAIL backpressure_hold_%0d: vld/rdy/bout/diff=%b required 1000111",
                         i, {out_valid_o, in_ready_o, bout_o, diff_o});
            end
            tick();
        end
        handshake();
        checks++;
        if ({in_ready_o, out_valid_o, busy_o, bout_o, diff_o} !== {3'b100, 5'd7}) begin
            errors++;
            $display("FAIL backpressure_release: rdy/vld/busy/bout/diff=%b required 10000111",
                     {in_ready_o, out_valid_o, busy_o, bout_o, diff_o});
        end
    endtask

    task automatic test_protocol();
        int guard;
        a_i = 4'd9; b_i = 4'd3; bin_i = 1'b0; in_valid_i = 1'b1;
        tick();
        guard = 0;
        while (!out_valid_o && guard < 20) begin
            in_valid_i = ~in_valid_i;
            a_i = 4'($urandom_range(0, 15));
            b_i = 4'($urandom_range(0, 15));
            bin_i = 1'($urandom_range(0, 1));
            checks++;
            if (in_ready_o !== 1'b0) begin
                errors++;
                $display("FAIL protocol_ready_run: in_ready=%0b required 0", in_ready_o);
            end
            tick();
            guard++;
        end
        for (int i = 0; i < 3; i++) begin
            in_valid_i = 1'b1;
            a_i = 4'($urandom_range(0, 15));
            tick();
        end
        in_valid_i = 1'b0;
        checks++;
        if ({out_valid_o, in_ready_o, bout_o, diff_o} !== {2'b10, 5'd6}) begin
            errors++;
            $display("FAIL protocol_result: vld/rdy/bout/diff=%b required 1000110",
                     {out_valid_o, in_ready_o, bout_o, diff_o});
        end
        handshake();
    endtask

    task automatic test_back_to_back();
        int t_acc [4];
        logic [W-1:0] xa, xb;
        logic xc;
        logic [W:0] exp;
        int guard;
        out_ready_i = 1'b1;
        in_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            xa = 4'($urandom_range(0, 15));
            xb = 4'($urandom_range(0, 15));
            xc = 1'($urandom_range(0, 1));
            a_i = xa; b_i = xb; bin_i = xc;
            exp = ref_sub(xa, xb, xc);
            guard = 0;
            while (!in_ready_o && guard < 20) begin
                tick();
                guard++;
            end
            tick();
            t_acc[i] = cyc;
            guard = 0;
            while (!out_valid_o && guard < 20) begin
                tick();
                guard++;
            end
            checks++;
            if ({out_valid_o, bout_o, diff_o} !== {1'b1, exp}) begin
                errors++;
                $display("FAIL b2b_result_%0d: vld/{bout,diff}=%b required %b", i,
                         {out_valid_o, bout_o, diff_o}, {1'b1, exp});
            end
            if (i > 0) begin
                checks++;
                if (t_acc[i] - t_acc[i-1] !== W + 2) begin
                    errors++;
                    $display("FAIL b2b_interval_%0d: interval=%0d required %0d", i,
                             t_acc[i] - t_acc[i-1], W + 2);
                end
            end
        end
        in_valid_i = 1'b0;
        tick();
        out_ready_i = 1'b0;
        checks++;
        if ({in_ready_o, out_valid_o} !== 2'b10) begin
            errors++;
            $display("FAIL b2b_drain: in_ready/out_valid=%b required 10", {in_ready_o, out_valid_o});
        end
    endtask

    task automatic test_random();
        logic [W-1:0] xa, xb;
        logic xc;
        logic [W:0] exp;
        int lat, stall;
        for (int i = 0; i < 1000; i++) begin
            xa = 4'($urandom_range(0, 15));
            xb = 4'($urandom_range(0, 15));
            xc = 1'($urandom_range(0, 1));
            exp = ref_sub(xa, xb, xc);
            run_op(xa, xb, xc, lat);
            stall = $urandom_range(0, 3);
            for (int s = 0; s < stall; s++) tick();
            checks++;
            if ({out_valid_o, bout_o, diff_o} !== {1'b1, exp}) begin
                errors++;
                $display("FAIL random_%0d: a=%0d b=%0d bin=%0b vld/{bout,diff}=%b required %b",
                         i, xa, xb, xc, {out_valid_o, bout_o, diff_o}, {1'b1, exp});
            end
            handshake();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_borrow_wrap();
        test_backpressure();
        test_protocol();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
